// File: rtl/stream_ext_pkg.sv
// stream_extremum shared types and compare helpers.
// Values are left-aligned to CMP_W bits so one compare serves any D_W <= 64.
package stream_ext_pkg;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_MIN = 1'b1
  } mode_e;

  localparam int CMP_W = 64;

  function automatic int idx_w(input int cnt_w, input int n_lanes);
    return cnt_w + $clog2(n_lanes);
  endfunction

  function automatic int lane_w(input int n_lanes);
    return (n_lanes > 1) ? $clog2(n_lanes) : 1;
  endfunction

  // Shifting the sample up puts its sign bit at the MSB; the
  // zero-filled low bits do not change the ordering.
  function automatic logic [CMP_W-1:0] align(
    input logic [CMP_W-1:0] v,
    input int               w
  );
    return v << (CMP_W - w);
  endfunction

  // Strict: equal values are never better.
  function automatic logic is_better(
    input logic [CMP_W-1:0] a,
    input logic [CMP_W-1:0] b,
    input mode_e            mode,
    input logic             signed_cmp
  );
    logic gt;
    logic lt;
    if (signed_cmp) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    return (mode == MODE_MAX) ? gt : lt;
  endfunction

endpackage

// File: rtl/stream_ext_lane_reduce.sv
// One-beat lane reduction: best value and lowest winning lane.
// Ports: data (N_LANES packed samples), mode, best, lane.
module stream_ext_lane_reduce
  import stream_ext_pkg::*;
#(
  parameter int D_W     = 32,
  parameter int N_LANES = 4,
  parameter bit SIGNED  = 1'b1,
  parameter int LW      = 2
) (
  input  logic [N_LANES*D_W-1:0] data,
  input  mode_e                  mode,
  output logic [D_W-1:0]         best,
  output logic [LW-1:0]          lane
);

  logic [D_W-1:0] v [N_LANES];
  logic [LW-1:0]  l [N_LANES];

  // In-place pairwise tree: slot j of each level takes the better of
  // slots 2j (lower lanes) and 2j+1, keeping the left one on ties.
  always_comb begin
    for (int k = 0; k < N_LANES; k++) begin
      v[k] = data[k*D_W +: D_W];
      l[k] = LW'(k);
    end
    for (int w = N_LANES / 2; w >= 1; w = w / 2) begin
      for (int j = 0; j < w; j++) begin
        if (is_better(align(CMP_W'(v[2*j+1]), D_W),
                      align(CMP_W'(v[2*j]), D_W),
                      mode, SIGNED)) begin
          v[j] = v[2*j+1];
          l[j] = l[2*j+1];
        end else begin
          v[j] = v[2*j];
          l[j] = l[2*j];
        end
      end
    end
    best = v[0];
    lane = l[0];
  end

endmodule

// File: rtl/stream_extremum.sv
// Frame-level max/min over a valid/ready stream, one result per frame.
// Ports: clk, rst, mode, s_valid/s_ready/s_data/s_last, m_valid/m_ready/m_value/m_index/m_count/m_ovf.
module stream_extremum
  import stream_ext_pkg::*;
#(
  parameter  int D_W     = 32,
  parameter  int N_LANES = 4,
  parameter  bit SIGNED  = 1'b1,
  parameter  int CNT_W   = 16,
  localparam int IDX_W   = idx_w(CNT_W, N_LANES)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   mode,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [N_LANES*D_W-1:0] s_data,
  input  logic                   s_last,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [D_W-1:0]         m_value,
  output logic [IDX_W-1:0]       m_index,
  output logic [CNT_W-1:0]       m_count,
  output logic                   m_ovf
);

  localparam int LOG = $clog2(N_LANES);
  localparam int LW  = lane_w(N_LANES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_EMPTY,
    ST_ACCUM
  } state_e;

  state_e           state;
  logic [D_W-1:0]   acc_value;
  logic [IDX_W-1:0] acc_index;
  mode_e            acc_mode;
  logic [CNT_W-1:0] acc_cnt;
  logic             acc_ovf;

  mode_e            beat_mode;
  logic [D_W-1:0]   beat_best;
  logic [LW-1:0]    beat_lane;
  logic [CNT_W-1:0] beat_num;
  logic [IDX_W-1:0] beat_index;

  logic [D_W-1:0]   nxt_value;
  logic [IDX_W-1:0] nxt_index;
  logic [CNT_W-1:0] nxt_cnt;
  logic             nxt_ovf;
  logic             accept;

  assign s_ready = !m_valid || m_ready;
  assign accept  = s_valid && s_ready;

  // Mode is only taken from the port on a frame's first beat.
  assign beat_mode = (state == ST_EMPTY) ? mode_e'(mode) : acc_mode;
  assign beat_num  = (state == ST_EMPTY) ? '0 : acc_cnt;
  assign beat_index = (IDX_W'(beat_num) << LOG) | IDX_W'(beat_lane);

  stream_ext_lane_reduce #(
    .D_W     (D_W),
    .N_LANES (N_LANES),
    .SIGNED  (SIGNED),
    .LW      (LW)
  ) u_reduce (
    .data (s_data),
    .mode (beat_mode),
    .best (beat_best),
    .lane (beat_lane)
  );

  always_comb begin
    nxt_value = beat_best;
    nxt_index = beat_index;
    nxt_cnt   = CNT_W'(1);
    nxt_ovf   = 1'b0;
    if (state == ST_ACCUM) begin
      if (!is_better(align(CMP_W'(beat_best), D_W),
                     align(CMP_W'(acc_value), D_W),
                     acc_mode, SIGNED)) begin
        nxt_value = acc_value;
        nxt_index = acc_index;
      end
      nxt_cnt = (acc_cnt == CNT_MAX) ? acc_cnt : acc_cnt + CNT_W'(1);
      nxt_ovf = acc_ovf | (acc_cnt == CNT_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_EMPTY;
      acc_value <= '0;
      acc_index <= '0;
      acc_mode  <= MODE_MAX;
      acc_cnt   <= '0;
      acc_ovf   <= 1'b0;
      m_valid   <= 1'b0;
      m_value   <= '0;
      m_index   <= '0;
      m_count   <= '0;
      m_ovf     <= 1'b0;
    end else begin
      if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      if (accept) begin
        if (s_last) begin
          // Overrides the pop above: drain and reload in one cycle.
          m_valid <= 1'b1;
          m_value <= nxt_value;
          m_index <= nxt_index;
          m_count <= nxt_cnt;
          m_ovf   <= nxt_ovf;
          state   <= ST_EMPTY;
        end else begin
          acc_value <= nxt_value;
          acc_index <= nxt_index;
          acc_mode  <= beat_mode;
          acc_cnt   <= nxt_cnt;
          acc_ovf   <= nxt_ovf;
          state     <= ST_ACCUM;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_extremum.sv
// Scoreboard bench for stream_extremum: three configurations share stimulus.
// u0: signed CNT_W=16, u1: unsigned CNT_W=16, u2: signed CNT_W=3.
module tb_stream_extremum;

  typedef struct packed {
    logic [31:0] v;
    logic [17:0] i;
    logic [15:0] c;
    logic        o;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         mode;
  logic         s_valid;
  logic [127:0] s_data;
  logic         s_last;
  logic         m_ready;
  int           sel;

  logic        s_ready0, s_ready1, s_ready2;
  logic        m_valid0, m_valid1, m_valid2;
  logic [31:0] m_value0, m_value1, m_value2;
  logic [17:0] m_index0, m_index1;
  logic [4:0]  m_index2;
  logic [15:0] m_count0, m_count1;
  logic [2:0]  m_count2;
  logic        m_ovf0, m_ovf1, m_ovf2;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  int   pop_cyc0[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  stream_extremum #(.D_W(32), .N_LANES(4), .SIGNED(1'b1), .CNT_W(16)) u0 (
    .clk(clk), .rst(rst), .mode(mode),
    .s_valid(s_valid && sel == 0), .s_ready(s_ready0),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid0), .m_ready(m_ready), .m_value(m_value0),
    .m_index(m_index0), .m_count(m_count0), .m_ovf(m_ovf0)
  );

  stream_extremum #(.D_W(32), .N_LANES(4), .SIGNED(1'b0), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .mode(mode),
    .s_valid(s_valid && sel == 1), .s_ready(s_ready1),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid1), .m_ready(m_ready), .m_value(m_value1),
    .m_index(m_index1), .m_count(m_count1), .m_ovf(m_ovf1)
  );

  stream_extremum #(.D_W(32), .N_LANES(4), .SIGNED(1'b1), .CNT_W(3)) u2 (
    .clk(clk), .rst(rst), .mode(mode),
    .s_valid(s_valid && sel == 2), .s_ready(s_ready2),
    .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid2), .m_ready(m_ready), .m_value(m_value2),
    .m_index(m_index2), .m_count(m_count2), .m_ovf(m_ovf2)
  );

  function automatic logic [127:0] pk(input int a, input int b,
                                      input int c, input int d);
    return {d, c, b, a};
  endfunction

  function automatic logic rdy(input int k);
    case (k)
      0: return s_ready0;
      1: return s_ready1;
      default: return s_ready2;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic expect_res(input int k, input logic [31:0] v,
                            input logic [17:0] i, input logic [15:0] c,
                            input logic o);
    exp_t e;
    e = '{v: v, i: i, c: c, o: o};
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic pop_chk(input int k, input logic [31:0] v,
                         input logic [17:0] i, input logic [15:0] c,
                         input logic o);
    exp_t e;
    bit   have;
    have = 1'b0;
    e = '0;
    case (k)
      0: if (q0.size() > 0) begin have = 1'b1; e = q0.pop_front(); end
      1: if (q1.size() > 0) begin have = 1'b1; e = q1.pop_front(); end
      default: if (q2.size() > 0) begin have = 1'b1; e = q2.pop_front(); end
    endcase
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL result%0d unexpected v=%h i=%0d c=%0d o=%b",
               k, v, i, c, o);
    end else if (v !== e.v || c !== e.c || o !== e.o ||
                 (!e.o && i !== e.i)) begin
      n_bad++;
      $display("FAIL result%0d got v=%h i=%0d c=%0d o=%b want v=%h i=%0d c=%0d o=%b",
               k, v, i, c, o, e.v, e.i, e.c, e.o);
    end
  endtask

  // Monitors: a result transfers at the next posedge when both are high.
  always @(negedge clk) begin
    if (!rst && m_valid0 && m_ready) begin
      pop_chk(0, m_value0, m_index0, m_count0, m_ovf0);
      pop_cyc0.push_back(cyc);
    end
  end

  always @(negedge clk) begin
    if (!rst && m_valid1 && m_ready)
      pop_chk(1, m_value1, m_index1, m_count1, m_ovf1);
  end

  always @(negedge clk) begin
    if (!rst && m_valid2 && m_ready)
      pop_chk(2, m_value2, 18'(m_index2), 16'(m_count2), m_ovf2);
  end

  task automatic beat(input int k, input logic [127:0] d,
                      input logic last, input logic md);
    bit r;
    r = 1'b0;
    sel = k;
    s_data = d;
    s_last = last;
    mode = md;
    s_valid = 1'b1;
    for (int n = 0; n < 50 && !r; n++) begin
      @(negedge clk);
      r = rdy(k);
      @(posedge clk);
      #1;
    end
    if (!r) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept%0d timeout", k);
    end
    s_valid = 1'b0;
    s_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    mode = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    s_last = 1'b0;
    m_ready = 1'b1;
    sel = 0;
    idle(3);
    rst = 1'b0;

    chk("rst_s_ready0", s_ready0, 1);
    chk("rst_m_valid0", m_valid0, 0);
    chk("rst_m_value0", m_value0, 0);
    chk("rst_m_index0", m_index0, 0);
    chk("rst_m_count0", m_count0, 0);
    chk("rst_m_ovf0", m_ovf0, 0);
    chk("rst_m_valid1", m_valid1, 0);
    chk("rst_m_valid2", m_valid2, 0);

    // Signed max, tie 9/9 resolves to lane 2.
    expect_res(0, 32'd9, 18'd2, 16'd2, 1'b0);
    beat(0, pk(3, -7, 9, 9), 1'b0, 1'b0);
    beat(0, pk(2, 1, 0, -1), 1'b1, 1'b0);
    chk("latency_m_valid", m_valid0, 1);

    // Min, single beat: unsigned vs signed.
    expect_res(1, 32'd0, 18'd3, 16'd1, 1'b0);
    beat(1, pk(5, -1, 5, 0), 1'b1, 1'b1);
    expect_res(0, 32'hFFFF_FFFF, 18'd1, 16'd1, 1'b0);
    beat(0, pk(5, -1, 5, 0), 1'b1, 1'b1);

    // Cross-beat tie keeps earlier index; mid-frame mode ignored.
    expect_res(0, 32'd5, 18'd11, 16'd3, 1'b0);
    beat(0, pk(1, 1, 1, 1), 1'b0, 1'b0);
    beat(0, pk(1, 1, 1, 1), 1'b0, 1'b1);
    beat(0, pk(0, 0, 0, 5), 1'b1, 1'b1);

    // Unsigned min across two beats.
    expect_res(1, 32'd7, 18'd4, 16'd2, 1'b0);
    beat(1, pk(10, 20, 30, 40), 1'b0, 1'b1);
    beat(1, pk(7, 7, 50, 60), 1'b1, 1'b0);

    // Backpressure with a second frame waiting.
    idle(2);
    m_ready = 1'b0;
    expect_res(0, 32'd8, 18'd1, 16'd1, 1'b0);
    beat(0, pk(4, 8, 2, 1), 1'b1, 1'b0);
    expect_res(0, 32'd1, 18'd3, 16'd1, 1'b0);
    fork
      beat(0, pk(4, 8, 2, 1), 1'b1, 1'b1);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_s_ready", s_ready0, 0);
          chk("bp_m_value", m_value0, 8);
          chk("bp_m_index", m_index0, 1);
        end
        @(posedge clk);
        #1;
        m_ready = 1'b1;
      end
    join
    chk("pop_load_m_valid", m_valid0, 1);
    chk("pop_load_m_value", m_value0, 1);

    // Back-to-back single-beat frames.
    idle(3);
    pop_cyc0.delete();
    for (int v = 0; v < 10; v++) begin
      expect_res(0, 32'(v), 18'd0, 16'd1, 1'b0);
      beat(0, pk(v, 0, 0, 0), 1'b1, 1'b0);
    end
    idle(3);
    chk("b2b_count", pop_cyc0.size(), 10);
    for (int i = 1; i < 10 && i < pop_cyc0.size(); i++)
      chk("b2b_gap", pop_cyc0[i] - pop_cyc0[i-1], 1);

    // Count saturation with CNT_W=3.
    expect_res(2, 32'd9, 18'd0, 16'd7, 1'b1);
    for (int b = 1; b <= 9; b++)
      beat(2, pk(b, 0, 0, 0), b == 9, 1'b0);
    expect_res(2, 32'd9, 18'd5, 16'd2, 1'b0);
    beat(2, pk(3, 1, 4, 1), 1'b0, 1'b0);
    beat(2, pk(5, 9, 2, 6), 1'b1, 1'b0);

    // Reset in beat 3 of a 5-beat frame.
    idle(3);
    beat(0, pk(100, 100, 100, 100), 1'b0, 1'b0);
    beat(0, pk(100, 100, 100, 100), 1'b0, 1'b0);
    sel = 0;
    s_data = pk(100, 100, 100, 100);
    s_valid = 1'b1;
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    s_valid = 1'b0;
    chk("mid_rst_m_valid", m_valid0, 0);
    chk("mid_rst_m_value", m_value0, 0);
    chk("mid_rst_m_index", m_index0, 0);
    chk("mid_rst_m_count", m_count0, 0);
    chk("mid_rst_m_ovf", m_ovf0, 0);
    chk("mid_rst_s_ready", s_ready0, 1);
    expect_res(0, 32'd4, 18'd3, 16'd2, 1'b0);
    beat(0, pk(1, 2, 3, 4), 1'b0, 1'b0);
    beat(0, pk(0, 0, 0, 0), 1'b1, 1'b0);

    idle(4);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("q2_drained", q2.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_extremum.md
# stream_extremum

Streaming frame-level extremum unit: consumes a valid/ready stream of N_LANES packed samples per beat, delimited by s_last, and returns one result per frame. Each result carries the maximum or minimum value, its flat sample index and the frame beat count. It sits after the running accumulators in the streaming arithmetic chain and feeds downstream scaling/normalisation blocks. It supports runtime max/min selection, signed or unsigned compare, and a registered output with backpressure.

## Interface
- D_W, 32, sample width in bits
- N_LANES, 4, samples per input beat (power of two, 1..16)
- SIGNED, 1, 1 = two's-complement compare, 0 = unsigned
- CNT_W, 16, beat-counter width; index width IDX_W = CNT_W + log2(N_LANES)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mode  in  1  0 = max, 1 = min; sampled on the first beat of each frame
- s_valid  in  1  input beat valid
- s_ready  out  1  input beat accepted when s_valid && s_ready
- s_data  in  N_LANES*D_W  lane k occupies bits [k*D_W +: D_W]
- s_last  in  1  final beat of frame
- m_valid  out  1  result valid
- m_ready  in  1  result consumed when m_valid && m_ready
- m_value  out  D_W  extremum of frame
- m_index  out  IDX_W  beat*N_LANES + lane of extremum
- m_count  out  CNT_W  beats in frame (saturating)
- m_ovf  out  1  frame exceeded 2^CNT_W-1 beats; m_index undefined when set

## Operation
- Per beat: combinational lane reduction gives best value and lane. Ties resolve to the lowest lane.
- Accumulator states are EMPTY and ACCUM. In EMPTY, an accepted beat loads acc_value, acc_index and acc_mode (latched from mode), sets beat count to 1 and moves to ACCUM.
- In ACCUM, an accepted beat replaces acc_value/acc_index only if it is strictly better under acc_mode. Ties keep the earlier index. Count increments, saturating at 2^CNT_W-1. A further beat at saturation sets the sticky ovf bit.
- An accepted beat with s_last transfers the final result (including that beat) to the output register. The accumulator returns to EMPTY. A single-beat frame is legal.
- mode changes mid-frame are ignored until the next frame start.
- Output register holds m_value/m_index/m_count/m_ovf stable while m_valid && !m_ready.
- s_ready = !m_valid || m_ready. The input stalls only while a result is pending and not being drained.
- Reset, including mid-frame: accumulator to EMPTY, partial frame discarded, m_valid=0, m_value=0, m_index=0, m_count=0, m_ovf=0, ovf sticky cleared. s_ready is 1 in the first cycle after reset.

## Timing
- Latency: last beat accepted at edge t gives m_valid=1 after edge t, with no bubble.
- Back-to-back frames: with m_ready held high, one result per frame and full input throughput (1 beat/cycle).
- Pop and new beat in the same cycle are both accepted. A result pop and a new last beat in the same cycle load the new result with m_valid remaining 1.
- Frames continue to be accepted while m_valid=1 only in cycles where m_ready=1.
- One registered stage only. The lane tree is combinational, depth log2(N_LANES).

## Structure
- Package stream_ext_pkg holds:
  - typedef mode_e (MODE_MAX=1'b0, MODE_MIN=1'b1)
  - function is_better(a, b, mode, signed_cmp), strict compare
  - localparam helper for IDX_W
- Sub-module stream_ext_lane_reduce: parametrised binary tree returning best value and lowest winning lane index for one beat. Shared with any future top-k block.
- Top module holds the accumulator FSM, counters and output register.

## Test plan
- N_LANES=4, SIGNED=1, mode=max, frame beats {[3,-7,9,9]}, [2,1,0,-1], last → m_value=9, m_index=2, m_count=2, m_ovf=0, one cycle after last beat.
- mode=min, SIGNED=0, single beat [5,0xFFFFFFFF,5,0] with last → m_value=0, m_index=3, m_count=1. With SIGNED=1 the same beat gives m_value=-1, m_index=1.
- Backpressure: hold m_ready=0 for 5 cycles with a second frame pending → s_ready=0 and outputs stable. Raise m_ready → first result popped, second frame's beat accepted in the same cycle.
- Back-to-back: 10 single-beat frames of values 0..9, m_ready=1 → 10 results in 10 consecutive cycles, each m_index=0, m_count=1.
- CNT_W=3: 9-beat frame → m_count=7, m_ovf=1. The next frame of 2 beats → m_ovf=0, m_count=2.
- Assert rst in beat 3 of a 5-beat frame → all outputs 0, m_valid=0. The following 2-beat frame yields a result computed only from its own beats.
